// File: rtl/hand_bus_responder_if.sv
// UART-side byte interface of the hand bus responder.
// slave: the responder's view (consumes rx bytes, drives tx bytes).
// master: the uart_rx/uart_tx side of the link.
interface hand_bus_responder_if;
  logic [7:0] rx_data;
  logic       rx_data_ready;
  logic [7:0] tx_data;
  logic       tx_transmit;
  logic       tx_active;

  modport slave (
    input  rx_data,
    input  rx_data_ready,
    input  tx_active,
    output tx_data,
    output tx_transmit
  );

  modport master (
    output rx_data,
    output rx_data_ready,
    output tx_active,
    input  tx_data,
    input  tx_transmit
  );
endinterface

// File: rtl/hand_bus_responder.sv
// Slave-side icebus protocol engine for the hand board.
// Hunts for request/command headers, collects and CRC-checks frames, applies motor setpoints
// and answers status requests with a 39-byte response after a bus turnaround delay.
// Optional macro BROADCAST_ID_EN: commands to id 8'hFF are accepted by every board and
// requests to id 8'hFF are never answered.
module hand_bus_responder #(
  parameter int unsigned CLK_FREQ_HZ                 = 50_000_000,
  parameter logic [31:0] STATUS_REQUEST_HEADER       = 32'h1CE1CEBB,
  parameter logic [31:0] HAND_COMMAND_HEADER         = 32'h0DA5C0DE,
  parameter logic [31:0] HAND_STATUS_RESPONSE_HEADER = 32'hB16B00B5,
  parameter int unsigned TURNAROUND_CYCLES           = 500,
  parameter int unsigned BYTE_TIMEOUT_CYCLES         = 100_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              my_id,
  hand_bus_responder_if.slave     bus,
  input  logic signed [3:0][23:0] position,
  input  logic signed [3:0][15:0] current,
  output logic signed [3:0][23:0] setpoint,
  output logic                    setpoint_update,
  output logic [31:0]             frames_received,
  output logic [31:0]             crc_errors
);

  if (CLK_FREQ_HZ == 0 || TURNAROUND_CYCLES == 0) begin : g_bad_params
    $error("hand_bus_responder: CLK_FREQ_HZ and TURNAROUND_CYCLES must be nonzero");
  end

  typedef enum logic [2:0] {StHunt, StCollect, StCheck, StTurnaround, StCrcGen, StSend} state_e;

  // MSB-first CRC16, poly 0x8005, one byte per call.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // Byte k (0..32) of the 33-byte response payload, first byte in the top bits.
  function automatic logic [7:0] payload_byte(input logic [263:0] pl, input logic [5:0] k);
    logic [263:0] sh;
    sh = pl << {k, 3'b000};
    return sh[263:256];
  endfunction

  // Byte idx (0..38) of the full response frame.
  function automatic logic [7:0] resp_byte(input logic [5:0] idx, input logic [263:0] pl,
                                           input logic [15:0] crc);
    logic [31:0] hdr;
    logic [7:0]  b;
    hdr = HAND_STATUS_RESPONSE_HEADER << {idx[1:0], 3'b000};
    if (idx < 6'd4)        b = hdr[31:24];
    else if (idx < 6'd37)  b = payload_byte(pl, idx - 6'd4);
    else if (idx == 6'd37) b = crc[15:8];
    else                   b = crc[7:0];
    return b;
  endfunction

  state_e                 state_q, state_d;
  logic [31:0]            window_q, window_d;
  logic                   is_cmd_q, is_cmd_d;
  logic [3:0]             byte_cnt_q, byte_cnt_d;
  logic [15:0]            crc_q, crc_d;
  logic [15:0]            rx_crc_q, rx_crc_d;
  logic [103:0]           payload_q, payload_d;
  logic [31:0]            timer_q, timer_d;
  logic [263:0]           resp_q, resp_d;
  logic [5:0]             idx_q, idx_d;
  logic                   pending_q, pending_d;
  logic                   rx_ready_q, tx_active_q;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_transmit_q, tx_transmit_d;
  logic [3:0][23:0]       setpoint_q, setpoint_d;
  logic                   setpoint_update_q, setpoint_update_d;
  logic [31:0]            frames_q, frames_d;
  logic [31:0]            crc_err_q, crc_err_d;

  logic        rx_new;
  logic        tx_done;
  logic [31:0] window_next;
  logic [3:0]  plen;
  logic [7:0]  rx_id;
  logic        rx_is_bcast;
  logic        accept;

  assign rx_new      = bus.rx_data_ready & ~rx_ready_q;
  assign tx_done     = tx_active_q & ~bus.tx_active;
  assign window_next = {window_q[23:0], bus.rx_data};
  assign plen        = is_cmd_q ? 4'd13 : 4'd1;
  // Commands shift 13 bytes in, so the id ends up at the top; a request leaves it at the bottom.
  assign rx_id       = is_cmd_q ? payload_q[103:96] : payload_q[7:0];

`ifdef BROADCAST_ID_EN
  assign rx_is_bcast = (rx_id == 8'hFF);
`else
  assign rx_is_bcast = 1'b0;
`endif

  // Broadcast requests are dropped so that several boards never answer at once.
  assign accept = is_cmd_q ? ((rx_id == my_id) || rx_is_bcast)
                           : ((rx_id == my_id) && !rx_is_bcast);

  // Next-state and output logic for the receive/respond sequencer.
  always_comb begin
    state_d           = state_q;
    window_d          = window_q;
    is_cmd_d          = is_cmd_q;
    byte_cnt_d        = byte_cnt_q;
    crc_d             = crc_q;
    rx_crc_d          = rx_crc_q;
    payload_d         = payload_q;
    timer_d           = timer_q;
    resp_d            = resp_q;
    idx_d             = idx_q;
    pending_d         = pending_q;
    tx_data_d         = tx_data_q;
    tx_transmit_d     = 1'b0;
    setpoint_d        = setpoint_q;
    setpoint_update_d = 1'b0;
    frames_d          = frames_q;
    crc_err_d         = crc_err_q;

    unique case (state_q)
      StHunt: begin
        if (rx_new) begin
          window_d = window_next;
          if (window_next == STATUS_REQUEST_HEADER || window_next == HAND_COMMAND_HEADER) begin
            is_cmd_d   = (window_next == HAND_COMMAND_HEADER);
            byte_cnt_d = '0;
            crc_d      = 16'hFFFF;
            timer_d    = '0;
            state_d    = StCollect;
          end
        end
      end

      StCollect: begin
        if (rx_new) begin
          timer_d    = '0;
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (byte_cnt_q < plen) begin
            crc_d     = crc16_byte(crc_q, bus.rx_data);
            payload_d = {payload_q[95:0], bus.rx_data};
          end else begin
            rx_crc_d = {rx_crc_q[7:0], bus.rx_data};
          end
          if (byte_cnt_q + 4'd1 == plen + 4'd2) state_d = StCheck;
        end else if (timer_q >= BYTE_TIMEOUT_CYCLES) begin
          window_d = '0;
          state_d  = StHunt;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      StCheck: begin
        window_d = '0;
        state_d  = StHunt;
        if (crc_q != rx_crc_q) begin
          crc_err_d = crc_err_q + 32'd1;
        end else if (accept) begin
          frames_d = frames_q + 32'd1;
          if (is_cmd_q) begin
            setpoint_d[0]     = payload_q[95:72];
            setpoint_d[1]     = payload_q[71:48];
            setpoint_d[2]     = payload_q[47:24];
            setpoint_d[3]     = payload_q[23:0];
            setpoint_update_d = 1'b1;
          end else begin
            resp_d  = {my_id, position[0], position[1], position[2], position[3],
                       current[0], current[1], current[2], current[3],
                       setpoint_q[0], setpoint_q[1], setpoint_q[2], setpoint_q[3]};
            crc_d   = 16'hFFFF;
            timer_d = '0;
            state_d = StTurnaround;
          end
        end
      end

      StTurnaround: begin
        if (timer_q >= TURNAROUND_CYCLES - 1) begin
          idx_d   = '0;
          state_d = StCrcGen;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      // One payload byte per cycle: 33 cycles.
      StCrcGen: begin
        crc_d = crc16_byte(crc_q, payload_byte(resp_q, idx_q));
        if (idx_q == 6'd32) begin
          idx_d     = '0;
          pending_d = 1'b0;
          state_d   = StSend;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end

      StSend: begin
        if (pending_q && tx_done) begin
          pending_d = 1'b0;
          if (idx_q == 6'd38) begin
            window_d = '0;
            state_d  = StHunt;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end else if (!pending_q && !bus.tx_active) begin
          tx_transmit_d = 1'b1;
          tx_data_d     = resp_byte(idx_q, resp_q, crc_q);
          pending_d     = 1'b1;
        end
      end

      default: state_d = StHunt;
    endcase
  end

  // State and output registers; reset drops tx_transmit immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= StHunt;
      window_q          <= '0;
      is_cmd_q          <= 1'b0;
      byte_cnt_q        <= '0;
      crc_q             <= '0;
      rx_crc_q          <= '0;
      payload_q         <= '0;
      timer_q           <= '0;
      resp_q            <= '0;
      idx_q             <= '0;
      pending_q         <= 1'b0;
      rx_ready_q        <= 1'b0;
      tx_active_q       <= 1'b0;
      tx_data_q         <= '0;
      tx_transmit_q     <= 1'b0;
      setpoint_q        <= '0;
      setpoint_update_q <= 1'b0;
      frames_q          <= '0;
      crc_err_q         <= '0;
    end else begin
      state_q           <= state_d;
      window_q          <= window_d;
      is_cmd_q          <= is_cmd_d;
      byte_cnt_q        <= byte_cnt_d;
      crc_q             <= crc_d;
      rx_crc_q          <= rx_crc_d;
      payload_q         <= payload_d;
      timer_q           <= timer_d;
      resp_q            <= resp_d;
      idx_q             <= idx_d;
      pending_q         <= pending_d;
      rx_ready_q        <= bus.rx_data_ready;
      tx_active_q       <= bus.tx_active;
      tx_data_q         <= tx_data_d;
      tx_transmit_q     <= tx_transmit_d;
      setpoint_q        <= setpoint_d;
      setpoint_update_q <= setpoint_update_d;
      frames_q          <= frames_d;
      crc_err_q         <= crc_err_d;
    end
  end

  assign bus.tx_data      = tx_data_q;
  assign bus.tx_transmit  = tx_transmit_q;
  assign setpoint         = setpoint_q;
  assign setpoint_update  = setpoint_update_q;
  assign frames_received  = frames_q;
  assign crc_errors       = crc_err_q;

endmodule

// File: tb/tb_hand_bus_responder.sv
// Self-checking bench for hand_bus_responder: table-driven frames, hand-written timeout and
// reset-mid-send sequences, then randomized frames checked against a frame-level model.
`timescale 1ns/1ps
module tb_hand_bus_responder;
  localparam int unsigned TurnCycles    = 40;
  localparam int unsigned TimeoutCycles = 300;
  localparam int unsigned TxBusy        = 6;
  localparam logic [7:0]  MyId          = 8'h06;
  localparam logic [31:0] ReqHdr        = 32'h1CE1CEBB;
  localparam logic [31:0] CmdHdr        = 32'h0DA5C0DE;
  localparam logic [31:0] RespHdr       = 32'hB16B00B5;
`ifdef BROADCAST_ID_EN
  localparam bit Bcast = 1'b1;
`else
  localparam bit Bcast = 1'b0;
`endif

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    bit               is_cmd;
    logic [7:0]       id;
    bit               corrupt;
    logic [3:0][23:0] sp;
    bit               exp_reply;
    bit               exp_update;
    bit               exp_crc_err;
  } vec_t;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [7:0]              my_id;
  logic signed [3:0][23:0] position;
  logic signed [3:0][15:0] current;
  logic signed [3:0][23:0] setpoint;
  logic                    setpoint_update;
  logic [31:0]             frames_received;
  logic [31:0]             crc_errors;

  hand_bus_responder_if bus ();

  hand_bus_responder #(
    .TURNAROUND_CYCLES  (TurnCycles),
    .BYTE_TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .my_id          (my_id),
    .bus            (bus),
    .position       (position),
    .current        (current),
    .setpoint       (setpoint),
    .setpoint_update(setpoint_update),
    .frames_received(frames_received),
    .crc_errors     (crc_errors)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [3:0][23:0] m_sp;
  int unsigned      m_frames;
  int unsigned      m_crcerr;

  bytes_t tx_q;
  int     upd_cnt = 0;
  int     first_tx_cyc = -1;
  vec_t   vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc16(input bytes_t b);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (b[i]) begin
      c = c ^ {b[i], 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
    end
    return c;
  endfunction

  // uart_tx stand-in: capture every start pulse, then stay busy for TxBusy cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.tx_transmit === 1'b1) begin
        if (tx_q.size() == 0) first_tx_cyc = cyc;
        tx_q.push_back(bus.tx_data);
      end
      if (setpoint_update === 1'b1) upd_cnt++;
    end
  end

  initial begin
    bus.tx_active = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_transmit === 1'b1) begin
        bus.tx_active = 1'b1;
        repeat (TxBusy) @(negedge clk);
        bus.tx_active = 1'b0;
      end
    end
  end

  // Each byte holds rx_data_ready high for three cycles; it must count once.
  task automatic send_bytes(input bytes_t f);
    foreach (f[i]) begin
      @(negedge clk);
      bus.rx_data       = f[i];
      bus.rx_data_ready = 1'b1;
      repeat (3) @(negedge clk);
      bus.rx_data_ready = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic add_vec(input bit is_cmd, input logic [7:0] id, input bit corrupt,
                         input logic [3:0][23:0] sp, input bit rep, input bit upd, input bit ce);
    vec_t v;
    v.is_cmd = is_cmd; v.id = id; v.corrupt = corrupt; v.sp = sp;
    v.exp_reply = rep; v.exp_update = upd; v.exp_crc_err = ce;
    vecs.push_back(v);
  endtask

  task automatic run_frame(input string tag, input bit is_cmd, input logic [7:0] id,
                           input logic [3:0][23:0] sp, input bit corrupt, input int n_garbage,
                           input bit exp_reply, input bit exp_update, input bit exp_crc_err);
    bytes_t      f, pl, rp, exp_r;
    logic [15:0] c, rc;
    logic [31:0] hdr;
    int          upd0, t, rx_end, lat;

    if (exp_crc_err) m_crcerr++;
    if (exp_update) begin
      m_sp = sp;
      m_frames++;
    end
    if (exp_reply) m_frames++;

    pl.push_back(id);
    if (is_cmd) for (int i = 0; i < 4; i++) for (int k = 2; k >= 0; k--) pl.push_back(sp[i][8*k +: 8]);
    c = crc16(pl);
    if (corrupt) c[7:0] = ~c[7:0];
    hdr = is_cmd ? CmdHdr : ReqHdr;
    for (int k = 0; k < n_garbage; k++) f.push_back(8'($urandom));
    for (int k = 3; k >= 0; k--) f.push_back(hdr[8*k +: 8]);
    foreach (pl[k]) f.push_back(pl[k]);
    f.push_back(c[15:8]);
    f.push_back(c[7:0]);

    tx_q.delete();
    first_tx_cyc = -1;
    upd0 = upd_cnt;
    send_bytes(f);
    rx_end = cyc;

    if (exp_reply) begin
      t = 0;
      while (tx_q.size() < 39 && t < 3000) begin
        @(negedge clk);
        t++;
      end
      repeat (20) @(negedge clk);
    end else begin
      repeat (TurnCycles + 120) @(negedge clk);
    end

    check({tag, " tx byte count"}, tx_q.size(), exp_reply ? 39 : 0);
    if (exp_reply && tx_q.size() == 39) begin
      rp.push_back(MyId);
      for (int i = 0; i < 4; i++) for (int k = 2; k >= 0; k--) rp.push_back(position[i][8*k +: 8]);
      for (int i = 0; i < 4; i++) for (int k = 1; k >= 0; k--) rp.push_back(current[i][8*k +: 8]);
      for (int i = 0; i < 4; i++) for (int k = 2; k >= 0; k--) rp.push_back(m_sp[i][8*k +: 8]);
      rc = crc16(rp);
      for (int k = 3; k >= 0; k--) exp_r.push_back(RespHdr[8*k +: 8]);
      foreach (rp[k]) exp_r.push_back(rp[k]);
      exp_r.push_back(rc[15:8]);
      exp_r.push_back(rc[7:0]);
      for (int i = 0; i < 39; i++) check($sformatf("%s resp byte %0d", tag, i), tx_q[i], exp_r[i]);
      lat = first_tx_cyc - rx_end;
      check({tag, " turnaround window"},
            (lat >= int'(TurnCycles) && lat <= int'(TurnCycles) + 60), 1);
    end
    check({tag, " setpoint_update pulses"}, upd_cnt - upd0, exp_update ? 1 : 0);
    check({tag, " frames_received"}, frames_received, m_frames);
    check({tag, " crc_errors"}, crc_errors, m_crcerr);
    for (int i = 0; i < 4; i++) check($sformatf("%s setpoint%0d", tag, i), setpoint[i], m_sp[i]);
  endtask

  initial begin
    bytes_t      f, pl;
    logic [15:0] c;
    int          t;
    bit          is_cmd, corrupt, rep, upd;
    logic [7:0]  id;

    reset             = 1'b1;
    my_id             = MyId;
    bus.rx_data       = 8'h00;
    bus.rx_data_ready = 1'b0;
    position          = {24'h300000, 24'hFFFFFF, 24'h0ABCDE, 24'h000123};
    current           = {16'hFFF0, 16'h1234, 16'h8000, 16'h0042};
    m_sp              = '0;
    m_frames          = 0;
    m_crcerr          = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("reset tx_transmit", bus.tx_transmit, 0);
    check("reset tx_data", bus.tx_data, 0);
    check("reset setpoint", setpoint, 0);
    check("reset setpoint_update", setpoint_update, 0);
    check("reset frames_received", frames_received, 0);
    check("reset crc_errors", crc_errors, 0);

    add_vec(0, 8'h06, 0, '0, 1, 0, 0);
    add_vec(1, 8'h06, 0, {24'h7FFFFF, 24'h000000, 24'hFFFF9C, 24'h000064}, 0, 1, 0);
    add_vec(0, 8'h06, 0, '0, 1, 0, 0);
    add_vec(0, 8'h06, 1, '0, 0, 0, 1);
    add_vec(0, 8'h06, 0, '0, 1, 0, 0);
    add_vec(0, 8'h07, 0, '0, 0, 0, 0);
    add_vec(1, 8'h07, 0, {24'd4, 24'd3, 24'd2, 24'd1}, 0, 0, 0);
    add_vec(1, 8'h06, 0, {24'h000001, 24'hC0DE00, 24'hBB0DA5, 24'h1CE1CE}, 0, 1, 0);
    add_vec(1, 8'hFF, 0, {24'd8, 24'd7, 24'd6, 24'd5}, 0, Bcast, 0);
    add_vec(0, 8'hFF, 0, '0, 0, 0, 0);
    add_vec(1, 8'h06, 1, {24'd9, 24'd9, 24'd9, 24'd9}, 0, 0, 1);
    add_vec(0, 8'h06, 0, '0, 1, 0, 0);

    foreach (vecs[i])
      run_frame($sformatf("vec%0d", i), vecs[i].is_cmd, vecs[i].id, vecs[i].sp, vecs[i].corrupt,
                0, vecs[i].exp_reply, vecs[i].exp_update, vecs[i].exp_crc_err);

    // Half a command, then silence past the byte timeout; only the next request is answered.
    f = {8'h0D, 8'hA5, 8'hC0, 8'hDE, 8'h06, 8'h00, 8'h00};
    send_bytes(f);
    repeat (TimeoutCycles + 20) @(negedge clk);
    run_frame("after timeout", 0, MyId, '0, 0, 0, 1, 0, 0);

    // Reset while byte 10 of the response is on the wire.
    f.delete();
    pl.delete();
    pl.push_back(MyId);
    c = crc16(pl);
    for (int k = 3; k >= 0; k--) f.push_back(ReqHdr[8*k +: 8]);
    f.push_back(MyId);
    f.push_back(c[15:8]);
    f.push_back(c[7:0]);
    tx_q.delete();
    send_bytes(f);
    t = 0;
    while (tx_q.size() < 11 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("mid-send reached byte 10", tx_q.size(), 11);
    reset = 1'b1;
    #1;
    check("mid-send reset tx_transmit", bus.tx_transmit, 0);
    check("mid-send reset tx_data", bus.tx_data, 0);
    check("mid-send reset setpoint", setpoint, 0);
    check("mid-send reset setpoint_update", setpoint_update, 0);
    check("mid-send reset frames_received", frames_received, 0);
    check("mid-send reset crc_errors", crc_errors, 0);
    m_sp     = '0;
    m_frames = 0;
    m_crcerr = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (TxBusy + TurnCycles + 60) @(negedge clk);
    check("truncated frame stays truncated", tx_q.size(), 11);
    run_frame("after reset", 0, MyId, '0, 0, 0, 1, 0, 0);

    // Randomized frames against the frame-level rules.
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 4; i++) begin
        position[i] = 24'($urandom);
        current[i]  = 16'($urandom);
      end
      is_cmd  = 1'($urandom_range(0, 1));
      corrupt = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0, 1:    id = MyId;
        2:       id = 8'h07;
        default: id = 8'hFF;
      endcase
      upd = !corrupt && is_cmd && (id == MyId || (Bcast && id == 8'hFF));
      rep = !corrupt && !is_cmd && id == MyId && !(Bcast && id == 8'hFF);
      run_frame($sformatf("rand%0d", n), is_cmd, id,
                {24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom)}, corrupt,
                $urandom_range(0, 2), rep, upd, corrupt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
